// File: rtl/mdu_if.sv
// Handshake bundle between the EX-stage decode and the MDU controller.
// master: EX stage side (drives op/operands/flush); slave: mdu_ctrl.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             flush_i;
    logic             op_valid_i;
    logic [2:0]       mdu_op_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             stall_o;
    logic             busy_o;
    logic             hi_we_o;
    logic             lo_we_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flush_i, op_valid_i, mdu_op_i, src_a_i, src_b_i,
        input  stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o
    );

    modport slave (
        input  flush_i, op_valid_i, mdu_op_i, src_a_i, src_b_i,
        output stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: 2-cycle registered multiply, WIDTH-cycle
// restoring divide, mthi/mtlo pass-through, HI/LO write ports.
// Ports: clk, resetn (async, active low), bus (mdu_if.slave):
//   flush_i, op_valid_i, mdu_op_i, src_a_i, src_b_i in;
//   stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o out.
// Option: define DIV_ZERO_FAST_EN to finish divide-by-zero in one stall cycle.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  resetn,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             vld;
    logic             is_mul;
    logic             is_div;
    logic             is_sdiv;
    logic             start;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        vld     = bus.op_valid_i & ~bus.flush_i;
        is_mul  = (bus.mdu_op_i == OP_MULT) | (bus.mdu_op_i == OP_MULTU);
        is_sdiv = (bus.mdu_op_i == OP_DIV);
        is_div  = is_sdiv | (bus.mdu_op_i == OP_DIVU);
        start   = vld & (is_mul | is_div) & (state_q == S_IDLE);
        mthi_we = vld & (bus.mdu_op_i == OP_MTHI) & (state_q == S_IDLE);
        mtlo_we = vld & (bus.mdu_op_i == OP_MTLO) & (state_q == S_IDLE);

        abs_a = (is_sdiv & bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
        abs_b = (is_sdiv & bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;

        // a_q doubles as the dividend/quotient shift register.
        rem_sh = {rem_q, a_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        qbit   = ~diff[WIDTH];
        rem_nx = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {a_q[WIDTH-2:0], qbit};

        // One multiplier serves both: sign-extend only for mult.
        ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = is_div ? abs_a : bus.src_a_i;
                    b_d     = is_div ? abs_b : bus.src_b_i;
                    sgn_d   = (bus.mdu_op_i == OP_MULT);
                    qneg_d  = is_sdiv & (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
                    rneg_d  = is_sdiv & bus.src_a_i[WIDTH-1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = is_mul ? S_MUL : S_DIV;
`ifdef DIV_ZERO_FAST_EN
                    if (is_div && bus.src_b_i == '0) begin
                        hi_d    = bus.src_a_i;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_MUL: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = rneg_q ? -rem_nx : rem_nx;
                        lo_d    = qneg_q ? -quo_nx : quo_nx;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        bus.stall_o = start | (state_q == S_MUL) | (state_q == S_DIV);
        bus.busy_o  = (state_q != S_IDLE);
        bus.hi_we_o = ((state_q == S_DONE) & ~bus.flush_i) | mthi_we;
        bus.lo_we_o = ((state_q == S_DONE) & ~bus.flush_i) | mtlo_we;
        bus.hi_o    = mthi_we ? bus.src_a_i : hi_q;
        bus.lo_o    = mtlo_we ? bus.src_a_i : lo_q;
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed cases plus random op stream checked
// every cycle against a latency/arithmetic reference model.
module tb_mdu_ctrl;
    localparam int W = 32;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b1;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [2:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction

    // Architectural result {hi, lo} computed with plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned up;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'd0;
        case (op)
            OP_MULT: begin
                q   = sa * sb;
                res = q;
            end
            OP_MULTU: begin
                up  = {32'd0, a} * {32'd0, b};
                res = up;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    if (FAST) res = {a, 32'hFFFF_FFFF};
                    else res = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        if (op == OP_MULT || op == OP_MULTU) return 2;
        if (FAST && b == 32'd0) return 1;
        return W + 1;
    endfunction

    // Model: cycles remaining until the write cycle (0 = idle).
    int          mdl_rem = 0;
    logic [31:0] pend_hi = '0;
    logic [31:0] pend_lo = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl_rem <= 0;
        end else if (mdl_rem > 0) begin
            mdl_rem <= bus.flush_i ? 0 : mdl_rem - 1;
        end else if (bus.op_valid_i && !bus.flush_i && is_md(bus.mdu_op_i)) begin
            {pend_hi, pend_lo} <= ref_result(bus.mdu_op_i, bus.src_a_i, bus.src_b_i);
            mdl_rem <= ref_lat(bus.mdu_op_i, bus.src_b_i);
        end
    end

    int          wr_cnt = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(negedge clk) begin
        bit e_start, e_stall, e_busy, e_hwe, e_lwe, vld;
        logic [31:0] e_hi, e_lo;
        vld     = bus.op_valid_i && !bus.flush_i;
        e_start = mdl_rem == 0 && vld && is_md(bus.mdu_op_i);
        e_stall = e_start || mdl_rem > 1;
        e_busy  = mdl_rem > 0;
        if (mdl_rem == 1) begin
            e_hwe = !bus.flush_i;
            e_lwe = !bus.flush_i;
            e_hi  = pend_hi;
            e_lo  = pend_lo;
        end else begin
            e_hwe = mdl_rem == 0 && vld && bus.mdu_op_i == OP_MTHI;
            e_lwe = mdl_rem == 0 && vld && bus.mdu_op_i == OP_MTLO;
            e_hi  = bus.src_a_i;
            e_lo  = bus.src_a_i;
        end
        check("stall", 64'(bus.stall_o), 64'(e_stall));
        check("busy", 64'(bus.busy_o), 64'(e_busy));
        check("hi_we", 64'(bus.hi_we_o), 64'(e_hwe));
        check("lo_we", 64'(bus.lo_we_o), 64'(e_lwe));
        if (e_hwe && bus.hi_we_o) check("hi", 64'(bus.hi_o), 64'(e_hi));
        if (e_lwe && bus.lo_we_o) check("lo", 64'(bus.lo_o), 64'(e_lo));
        if (bus.hi_we_o || bus.lo_we_o) wr_cnt++;
        if (bus.hi_we_o) last_hi = bus.hi_o;
        if (bus.lo_we_o) last_lo = bus.lo_o;
    end

    task automatic idle_inputs();
        bus.op_valid_i = 1'b0;
        bus.mdu_op_i   = OP_NONE;
        bus.flush_i    = 1'b0;
    endtask

    // Hold an instruction in EX until stall drops; fl >= 0 flushes it then.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int fl, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        bus.op_valid_i = 1'b1;
        bus.mdu_op_i   = op;
        bus.src_a_i    = a;
        bus.src_b_i    = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (i == fl) bus.flush_i = 1'b1;
            @(negedge clk);
            if (bus.flush_i || !bus.stall_o) done = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
            bus.flush_i = 1'b0;
        end
        check("issue_done", 64'(done), 64'd1);
        idle_inputs();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int st, w0, fl;
        logic [31:0] ra, rb;
        logic [2:0] rop;

        idle_inputs();
        bus.src_a_i = '0;
        bus.src_b_i = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_we", 64'({bus.hi_we_o, bus.lo_we_o}), 64'd0);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        check("ref_div", ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2),
              64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_multu", ref_result(OP_MULTU, 32'hFFFF_FFFF, 32'd2),
              64'h0000_0001_FFFF_FFFE);
        check("ref_mult", ref_result(OP_MULT, 32'hFFFF_FFFF, 32'd2),
              64'hFFFF_FFFF_FFFF_FFFE);
        check("ref_divmin", ref_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF),
              64'h0000_0000_8000_0000);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, st);
        check("div_stalls", 64'(st), 64'd33);
        check("div_res", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(OP_DIVU, 32'd100, 32'd7, -1, st);
        check("divu_res", {last_hi, last_lo}, {32'd2, 32'd14});
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, -1, st);
        check("mult_stalls", 64'(st), 64'd2);
        check("mult_res", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, st);
        check("multu_res", {last_hi, last_lo}, 64'h0000_0001_FFFF_FFFE);

        w0 = wr_cnt;
        bus.op_valid_i = 1'b1;
        bus.mdu_op_i   = OP_DIV;
        bus.src_a_i    = 32'd1000;
        bus.src_b_i    = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i    = 1'b1;
        bus.op_valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_busy", 64'(bus.busy_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_nowr", 64'(wr_cnt), 64'(w0));
        issue(OP_MTLO, 32'h1234, 32'd0, -1, st);
        check("mtlo_stalls", 64'(st), 64'd0);
        check("mtlo_lo", 64'(last_lo), 64'h1234);

        w0 = wr_cnt;
        bus.op_valid_i = 1'b1;
        bus.mdu_op_i   = OP_MULT;
        bus.src_a_i    = 32'd7;
        bus.src_b_i    = 32'd9;
        @(posedge clk);
        #1;
        idle_inputs();
        resetn = 1'b0;
        #1;
        check("mrst_stall", 64'(bus.stall_o), 64'd0);
        check("mrst_busy", 64'(bus.busy_o), 64'd0);
        check("mrst_we", 64'({bus.hi_we_o, bus.lo_we_o}), 64'd0);
        check("mrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_nowr", 64'(wr_cnt), 64'(w0));
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, -1, st);
        check("mthi_stalls", 64'(st), 64'd0);
        check("mthi_hi", 64'(last_hi), 64'hA5A5_A5A5);

        issue(OP_DIVU, 32'h55, 32'd0, -1, st);
        check("dz_stalls", 64'(st), FAST ? 64'd1 : 64'd33);
        check("dz_res", {last_hi, last_lo}, 64'h0000_0055_FFFF_FFFF);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, st);
        check("divmin_res", {last_hi, last_lo}, 64'h0000_0000_8000_0000);

        bus.op_valid_i = 1'b1;
        bus.mdu_op_i   = OP_DIV;
        bus.flush_i    = 1'b1;
        @(negedge clk);
        check("fs_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("fs_busy", 64'(bus.busy_o), 64'd0);

        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            fl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 35)) : -1;
            issue(rop, ra, rb, fl, st);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller in the execute stage.
- Accepts mult, multu, div, divu, mthi and mtlo from the decoder, runs an iterative 32-cycle divider and a registered two-cycle multiplier, and stalls the pipeline while busy.
- Drives the HI/LO write ports.
- An exception flush aborts any operation in flight; an aborted operation never writes HI/LO.

Parameters:
- WIDTH, 32: operand/HI/LO width. The divider iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- flush_i  in  1  exception/eret flush; kills the EX instruction and any MDU operation
- op_valid_i  in  1  EX-stage instruction valid
- mdu_op_i  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
- src_a_i  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
- src_b_i  in  WIDTH  rt operand (divisor / multiplier)
- stall_o  out  1  pipeline stall request (combinational)
- busy_o  out  1  state is not IDLE
- hi_we_o  out  1  HI write enable
- lo_we_o  out  1  LO write enable
- hi_o  out  WIDTH  HI write data
- lo_o  out  WIDTH  LO write data

Behaviour:
- Reset: asynchronous on resetn low.
  - State goes to IDLE; counter, operand and result registers clear to 0.
  - All registered outputs are 0.
  - stall_o = 0.
- start = op_valid_i & ~flush_i & (mdu_op_i in mult/multu/div/divu) & state==IDLE.
- States and transitions:
  - IDLE: on start, latch operands.
    - mult/multu go to MUL.
    - div/divu go to DIV; load count=0 and the absolute values (signed div) or raw values (divu); record quotient sign = a[31]^b[31] and remainder sign = a[31].
  - MUL: compute the 2*WIDTH product from the latched operands (signed or unsigned), register it, go to DONE.
  - DIV: restoring division, one quotient bit per cycle, MSB first. count increments. When count==WIDTH-1, go to DONE with sign fixup applied.
  - DONE: hi_we_o = lo_we_o = 1 for exactly one cycle, then go to IDLE. start is ignored in DONE, so the same EX instruction never re-triggers.
- Results: hi_o = remainder, lo_o = quotient for div/divu; hi_o = product[63:32], lo_o = product[31:0] for mult/multu. hi_o/lo_o are valid whenever the write enables are high.
- mthi/mtlo: in IDLE with op_valid_i & ~flush_i, combinational single-cycle write with no stall.
  - mthi: hi_we_o=1, hi_o=src_a_i.
  - mtlo: lo_we_o=1, lo_o=src_a_i.
  - Outside IDLE these ops are held by stall_o and not executed.
- stall_o = start | state==MUL | state==DIV. It is low in DONE so the pipeline advances on the write cycle.
- Latency: mult is 2 stall cycles, write on cycle 3; div is 1+WIDTH stall cycles, write on cycle WIDTH+2.
- Divide by zero (macro off): runs the full WIDTH iterations. Unsigned core yields quotient 0xFFFFFFFF and remainder |a|, then sign fixup. The result is deterministic; software must not rely on it.
- flush_i:
  - In MUL, DIV or DONE, the next state is IDLE and no write occurs in that cycle (write enables gated by ~flush_i).
  - In IDLE, flush_i suppresses start and mthi/mtlo.
- Simultaneous flush and start: flush wins.
- resetn low mid-operation: immediate abort to IDLE, no write.
- Most-negative signed dividend: 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (wrap, no trap).

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
  - Defined: div/divu with src_b_i==0 goes IDLE to DONE directly (1 stall cycle). hi_o = src_a_i, lo_o = 0xFFFFFFFF, no sign fixup.
  - Undefined: divide by zero takes the full iterative path described above.

Test Plan:
- div a=0xFFFFFFF9 (-7), b=2 -> stall_o high 33 cycles; on cycle 34 hi_we_o=lo_we_o=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- divu a=100, b=7, then mult a=0xFFFFFFFF, b=2 back-to-back -> divu writes lo=14, hi=2; mult starts the cycle after DONE and writes hi=0xFFFFFFFF, lo=0xFFFFFFFE two stall cycles later; multu with the same operands writes hi=1, lo=0xFFFFFFFE.
- div started, flush_i pulsed at DIV count=10 -> next cycle IDLE, busy_o=0, no hi_we_o/lo_we_o at any later cycle; a following mtlo 0x1234 writes lo_o=0x1234 with no stall.
- resetn low for one cycle at mult MUL state -> all outputs 0, state IDLE, no write; a subsequent mthi 0xA5A5A5A5 gives hi_we_o=1 same cycle.
- divu a=0x55, b=0 -> macro off: 33 stall cycles, lo=0xFFFFFFFF, hi=0x55; macro on: 1 stall cycle, same values.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; flush_i together with start of div -> stall_o=0, no state change.
